// File: rtl/etroc_link_pkg.sv
// Shared types and default patterns for the serial link transmit/receive blocks.
package etroc_link_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_DATA  = 2'd2,
    ST_IDLE  = 2'd3
  } link_state_e;

  localparam int DEF_WORD_WIDTH = 40;

  localparam logic [DEF_WORD_WIDTH-1:0] DEF_TRAIN_PATTERN = {20{2'b10}};
  localparam logic [DEF_WORD_WIDTH-1:0] DEF_IDLE_PATTERN  = 40'h3C3C3C3C3C;

  function automatic int bitcnt_w(input int word_width);
    return $clog2(word_width);
  endfunction

  localparam int BITCNT_W = bitcnt_w(DEF_WORD_WIDTH);

endpackage

// File: rtl/bit_launcher_if.sv
// Parallel word handshake between the word source and the serializer.
// A word transfers on a rising clk edge where word_valid && word_ready are both 1.
// The source holds word_in and word_valid stable until that edge; word_ready
// only rises on word boundaries and never depends on word_valid.
interface bit_launcher_if #(
  parameter int WIDTH = 40
);
  logic [WIDTH-1:0] word_in;
  logic             word_valid;
  logic             word_ready;

  modport master (output word_in, output word_valid, input word_ready);
  modport slave  (input word_in, input word_valid, output word_ready);
endinterface

// File: rtl/majorityVoter.sv
// Bitwise 2-of-3 voter with a flag raised whenever the three copies disagree.
module majorityVoter #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  output logic [WIDTH-1:0] voted_o,
  output logic             mismatch_o
);
  assign voted_o    = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  assign mismatch_o = (a_i != b_i) || (a_i != c_i);
endmodule

// File: rtl/bit_launcher.sv
// Link transmit serializer: trains, idles or sends parallel words MSB first,
// with a self-correcting TMR bit counter and selectable launch edge.
module bit_launcher
  import etroc_link_pkg::*;
#(
  parameter int                    WORD_WIDTH    = DEF_WORD_WIDTH,
  parameter logic [WORD_WIDTH-1:0] TRAIN_PATTERN = DEF_TRAIN_PATTERN,
  parameter logic [WORD_WIDTH-1:0] IDLE_PATTERN  = DEF_IDLE_PATTERN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 falling_edge_launch_asyn,
  input  logic                 invert_pol,
  input  logic                 train_req,
  input  logic [7:0]           train_words,
  bit_launcher_if.slave        link,
  output logic                 dout,
  output logic                 frame_start,
  output logic                 training,
  output logic                 tmr_err,
  output link_state_e          state_o
);
  localparam int               CNT_W   = bitcnt_w(WORD_WIDTH);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WORD_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  link_state_e           state_q, state_d;
  logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]      cnt_a_q, cnt_b_q, cnt_c_q, cnt_voted, cnt_d;
  logic                  cnt_mismatch;
  logic                  train_pend_q, train_pend_d;
  logic [7:0]            train_cnt_q, train_cnt_d;
  logic                  frame_start_q, training_q, tmr_err_q;
  logic [1:0]            sync_q;
  logic                  fall_sel_q;
  logic                  neg_q;
  logic                  rise_bit;
  logic                  boundary, train_start, train_more;

  majorityVoter #(.WIDTH(CNT_W)) u_cnt_voter (
    .a_i        (cnt_a_q),
    .b_i        (cnt_b_q),
    .c_i        (cnt_c_q),
    .voted_o    (cnt_voted),
    .mismatch_o (cnt_mismatch)
  );

  assign boundary    = (cnt_voted == '0);
  assign train_start = train_pend_q && (train_words != 8'd0);
  assign train_more  = (state_q == ST_TRAIN) && (train_cnt_q != 8'd0);

  // Ready is a pure function of registered state, so a held word_valid can never be lost.
  assign link.word_ready = boundary && !train_start && !train_more && !rst;

  always_comb begin
    state_d      = state_q;
    shreg_d      = {shreg_q[WORD_WIDTH-2:0], 1'b0};
    train_cnt_d  = train_cnt_q;
    train_pend_d = train_pend_q | train_req;
    cnt_d        = cnt_voted - CNT_ONE;
    if (boundary) begin
      cnt_d        = CNT_TOP;
      train_pend_d = train_req;
      if (train_start) begin
        state_d     = ST_TRAIN;
        shreg_d     = TRAIN_PATTERN;
        train_cnt_d = train_words - 8'd1;
      end else if (train_more) begin
        state_d     = ST_TRAIN;
        shreg_d     = TRAIN_PATTERN;
        train_cnt_d = train_cnt_q - 8'd1;
      end else if (link.word_valid) begin
        state_d = ST_DATA;
        shreg_d = link.word_in;
      end else begin
        state_d = ST_IDLE;
        shreg_d = IDLE_PATTERN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_LOAD;
      shreg_q       <= '0;
      cnt_a_q       <= '0;
      cnt_b_q       <= '0;
      cnt_c_q       <= '0;
      train_pend_q  <= 1'b1;
      train_cnt_q   <= 8'd0;
      frame_start_q <= 1'b0;
      training_q    <= 1'b0;
      tmr_err_q     <= 1'b0;
      sync_q        <= 2'b00;
      fall_sel_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      cnt_a_q       <= cnt_d;
      cnt_b_q       <= cnt_d;
      cnt_c_q       <= cnt_d;
      train_pend_q  <= train_pend_d;
      train_cnt_q   <= train_cnt_d;
      frame_start_q <= boundary;
      training_q    <= (state_d == ST_TRAIN);
      tmr_err_q     <= tmr_err_q | cnt_mismatch;
      sync_q        <= {sync_q[0], falling_edge_launch_asyn};
      // Edge switch only between words so the bit stream stays gap-free.
      if (boundary) fall_sel_q <= sync_q[1];
    end
  end

  // The shift register MSB is the rising-launch flop; the negedge flop retimes it by half a clk.
  assign rise_bit = shreg_q[WORD_WIDTH-1] ^ invert_pol;

  always_ff @(negedge clk) begin
    neg_q <= rise_bit;
  end

  assign dout        = fall_sel_q ? neg_q : rise_bit;
  assign frame_start = frame_start_q;
  assign training    = training_q;
  assign tmr_err     = tmr_err_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_bit_launcher.sv
// Directed-plus-random bench for bit_launcher with a frame-level bit-stream reference model.
module tb_bit_launcher;
  localparam int            WW        = 40;
  localparam logic [WW-1:0] TRAIN_PAT = {20{2'b10}};
  localparam logic [WW-1:0] IDLE_PAT  = 40'h3C3C3C3C3C;
  localparam logic [WW-1:0] FIXED_W   = 40'h80_0000_0001;

  logic       clk;
  logic       rst;
  logic       falling_edge_launch_asyn;
  logic       invert_pol;
  logic       train_req;
  logic [7:0] train_words;
  logic       dout;
  logic       frame_start;
  logic       training;
  logic       tmr_err;
  etroc_link_pkg::link_state_e dbg_state;

  bit_launcher_if #(.WIDTH(WW)) link ();

  bit_launcher dut (
    .clk                      (clk),
    .rst                      (rst),
    .falling_edge_launch_asyn (falling_edge_launch_asyn),
    .invert_pol               (invert_pol),
    .train_req                (train_req),
    .train_words              (train_words),
    .link                     (link),
    .dout                     (dout),
    .frame_start              (frame_start),
    .training                 (training),
    .tmr_err                  (tmr_err),
    .state_o                  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: one entry per expected dout cycle = {bit, frame_start, training}
  logic [2:0] exp_q[$];
  int         n_tests;
  int         n_fail;

  // reference model state
  int         n_cyc;
  logic       m_pend;
  int         m_train_left;
  logic       m_fall;
  logic       m_tmr_err;
  logic       prev_bit;

  // word source and per-cycle requests
  int            src_mode;
  logic          src_valid;
  logic [WW-1:0] src_word;
  logic          req_next;
  logic          fall_next;
  logic          force_next;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp_v, n_cyc);
    end
  endtask

  task automatic next_source();
    logic [63:0] r;
    case (src_mode)
      1: begin
        src_valid = 1'b1;
        src_word  = FIXED_W;
      end
      2: begin
        r         = {$urandom(), $urandom()};
        src_valid = ($urandom_range(0, 3) != 0);
        src_word  = r[WW-1:0];
      end
      default: src_valid = 1'b0;
    endcase
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      rst = 1'b1;
      train_req = 1'b0;
      link.word_valid = 1'b0;
      falling_edge_launch_asyn = 1'b0;
      #6;
      if (i > 0) begin
        check("rst_dout", dout, invert_pol);
        check("rst_word_ready", link.word_ready, 1'b0);
        check("rst_frame_start", frame_start, 1'b0);
        check("rst_training", training, 1'b0);
        check("rst_tmr_err", tmr_err, 1'b0);
        check("rst_state", dbg_state, etroc_link_pkg::ST_LOAD);
      end
    end
    exp_q.delete();
    n_cyc        = 0;
    m_pend       = 1'b1;
    m_train_left = 0;
    m_fall       = 1'b0;
    m_tmr_err    = 1'b0;
    prev_bit     = invert_pol;
    src_valid    = 1'b0;
    req_next     = 1'b0;
    fall_next    = 1'b0;
    force_next   = 1'b0;
  endtask

  // One clock cycle of the run: drive, check both dout sample points, advance the model.
  task automatic run_cycle();
    logic [2:0]    e;
    logic          bnd, go_train, exp_ready, exp_early, accepted, trn, tmr_hit;
    logic [WW-1:0] frame;
    @(posedge clk);
    #1;
    rst = 1'b0;
    train_req = req_next;
    req_next = 1'b0;
    falling_edge_launch_asyn = fall_next;
    link.word_valid = src_valid;
    link.word_in = src_word;
    tmr_hit = force_next;
    if (tmr_hit) force dut.cnt_b_q = 6'd7;

    bnd = ((n_cyc % WW) == 0);
    if (n_cyc == 0) e = {invert_pol, 2'b00};
    else            e = exp_q.pop_front();
    go_train  = (m_pend && train_words != 8'd0) || (m_train_left != 0);
    exp_ready = bnd && !go_train;
    exp_early = m_fall ? prev_bit : e[2];

    #1;
    check("dout_early", dout, exp_early);
    #4;
    if (tmr_hit) begin
      release dut.cnt_b_q;
      force_next = 1'b0;
    end
    #1;
    check("dout", dout, e[2]);
    check("word_ready", link.word_ready, exp_ready);
    check("frame_start", frame_start, e[1]);
    check("training", training, e[0]);
    check("tmr_err", tmr_err, m_tmr_err);

    accepted = 1'b0;
    if (bnd) begin
      m_fall = (n_cyc == 0) ? 1'b0 : falling_edge_launch_asyn;
      trn = 1'b1;
      if (m_pend && train_words != 8'd0) begin
        frame = TRAIN_PAT;
        m_train_left = int'(train_words) - 1;
      end else if (m_train_left != 0) begin
        frame = TRAIN_PAT;
        m_train_left--;
      end else if (src_valid) begin
        frame = src_word;
        trn = 1'b0;
        accepted = 1'b1;
      end else begin
        frame = IDLE_PAT;
        trn = 1'b0;
      end
      for (int i = WW - 1; i >= 0; i--)
        exp_q.push_back({frame[i] ^ invert_pol, (i == WW - 1), trn});
    end
    m_pend = bnd ? train_req : (m_pend | train_req);
    if (tmr_hit) m_tmr_err = 1'b1;
    prev_bit = e[2];
    n_cyc++;
    if (accepted || !src_valid) next_source();
  endtask

  task automatic run_n(input int k);
    for (int i = 0; i < k; i++) run_cycle();
  endtask

  // Advance until the upcoming cycle puts bit b of a word on dout.
  task automatic run_to_bit(input int b);
    for (int i = 0; i < 2 * WW; i++) begin
      if (n_cyc >= 1 && (WW - 1 - ((n_cyc - 1) % WW)) == b) break;
      run_cycle();
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    invert_pol = 1'b0;
    train_words = 8'd3;
    train_req = 1'b0;
    falling_edge_launch_asyn = 1'b0;
    link.word_valid = 1'b0;
    link.word_in = '0;
    src_mode = 0;
    src_valid = 1'b0;
    src_word = '0;

    // training burst of 3 words, then idle
    do_reset(4);
    run_n(5 * WW);

    // fixed word held valid
    src_mode = 1;
    run_n(3 * WW);

    // random data, training request mid-word, then a restart during training
    src_mode = 2;
    run_n(2 * WW);
    run_to_bit(17);
    req_next = 1'b1;
    run_n(5 * WW);
    run_to_bit(17);
    req_next = 1'b1;
    run_n(WW + WW / 2);
    req_next = 1'b1;
    run_n(5 * WW);

    // corrupt one counter copy mid-word
    run_to_bit(20);
    force_next = 1'b1;
    run_n(3 * WW);

    // switch launch edge mid-word in both directions
    run_to_bit(20);
    fall_next = 1'b1;
    run_n(4 * WW);
    run_to_bit(11);
    fall_next = 1'b0;
    run_n(3 * WW);

    // inverted polarity, no training after reset
    invert_pol = 1'b1;
    train_words = 8'd0;
    src_mode = 0;
    do_reset(2);
    run_n(3 * WW);
    src_mode = 2;
    run_to_bit(5);
    req_next = 1'b1;
    run_n(3 * WW);

    // reset in the middle of a word with a random burst length, then falling launch
    train_words = 8'($urandom_range(1, 4));
    run_n(13 + $urandom_range(0, 20));
    do_reset(3);
    run_n(6 * WW);
    run_to_bit(30);
    fall_next = 1'b1;
    run_n(6 * WW);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
